// File: rtl/reg_file_pkg.sv
// Shared constants and helpers for the multi-port register file.
// Helpers work on the widest supported word; callers zero-extend and slice.
package reg_file_pkg;

    localparam int DATA_W_DEF   = 32;
    localparam int ADDR_W_DEF   = 5;
    localparam int NUM_RD_DEF   = 2;
    localparam int ZERO_REG_DEF = 1;

    localparam int DATA_W_MAX = 128;
    localparam int BE_W_MAX   = DATA_W_MAX / 8;
    localparam int ADDR_W_MAX = 16;

    function automatic logic [DATA_W_MAX-1:0] byte_merge(
        input logic [DATA_W_MAX-1:0] old_word,
        input logic [DATA_W_MAX-1:0] new_word,
        input logic [BE_W_MAX-1:0]   be
    );
        logic [DATA_W_MAX-1:0] merged;
        merged = old_word;
        for (int b = 0; b < BE_W_MAX; b++) begin
            if (be[b]) merged[8*b +: 8] = new_word[8*b +: 8];
        end
        return merged;
    endfunction

    function automatic logic zero_hit(
        input logic [ADDR_W_MAX-1:0] addr,
        input logic                  zero_en
    );
        return zero_en && (addr == '0);
    endfunction

endpackage

// File: rtl/reg_file_sb.sv
// Pending-write scoreboard: one busy bit per entry, set at issue, cleared at writeback.
// Lookups see this cycle's set/clear so reads and updates line up on the same edge.
module reg_file_sb #(
    parameter int ADDR_W = 5,
    parameter int NUM_RD = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     set,
    input  logic [ADDR_W-1:0]        set_addr,
    input  logic                     clr,
    input  logic [ADDR_W-1:0]        clr_addr,
    input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
    output logic [NUM_RD-1:0]        busy_nxt
);

    localparam int DEPTH = 2**ADDR_W;

    logic [DEPTH-1:0] busy_q;
    logic [DEPTH-1:0] busy_d;

    // Set is applied after clear so an issue and a writeback to one entry leave it busy.
    always_comb begin
        busy_d = busy_q;
        if (clr) busy_d[clr_addr] = 1'b0;
        if (set) busy_d[set_addr] = 1'b1;
    end

    always_comb begin
        busy_nxt = '0;
        for (int k = 0; k < NUM_RD; k++) begin
            busy_nxt[k] = busy_d[rd_addr[k*ADDR_W +: ADDR_W]];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) busy_q <= '0;
        else     busy_q <= busy_d;
    end

endmodule

// File: rtl/reg_file_mp.sv
// Multi-read-port register file with byte-enabled write, write-to-read forwarding,
// optional hardwired-zero entry 0 and a per-entry busy scoreboard.
module reg_file_mp
    import reg_file_pkg::*;
#(
    parameter int DATA_W   = DATA_W_DEF,
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int NUM_RD   = NUM_RD_DEF,
    parameter int ZERO_REG = ZERO_REG_DEF
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_RD-1:0]        rd_en,
    input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
    output logic [NUM_RD*DATA_W-1:0] rd_data,
    output logic [NUM_RD-1:0]        rd_busy,
    input  logic                     wr_en,
    input  logic [ADDR_W-1:0]        wr_addr,
    input  logic [DATA_W-1:0]        wr_data,
    input  logic [DATA_W/8-1:0]      wr_be,
    input  logic                     sb_set,
    input  logic [ADDR_W-1:0]        sb_addr
);

    localparam int   DEPTH   = 2**ADDR_W;
    localparam int   BE_W    = DATA_W / 8;
    localparam logic ZERO_EN = (ZERO_REG != 0);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] mem_d [DEPTH];
    logic [DATA_W-1:0] wr_merged;
    logic              wr_zero;
    logic              sb_zero;
    logic [NUM_RD-1:0] busy_nxt;

    assign wr_zero = zero_hit(ADDR_W_MAX'(wr_addr), ZERO_EN);
    assign sb_zero = zero_hit(ADDR_W_MAX'(sb_addr), ZERO_EN);

    always_comb begin
        logic [DATA_W_MAX-1:0] old_ext;
        logic [DATA_W_MAX-1:0] new_ext;
        logic [BE_W_MAX-1:0]   be_ext;
        logic [DATA_W_MAX-1:0] merge_ext_unused;
        old_ext = '0;
        new_ext = '0;
        be_ext  = '0;
        old_ext[DATA_W-1:0] = mem_q[wr_addr];
        new_ext[DATA_W-1:0] = wr_data;
        be_ext[BE_W-1:0]    = wr_be;
        merge_ext_unused    = byte_merge(old_ext, new_ext, be_ext);
        wr_merged           = merge_ext_unused[DATA_W-1:0];
    end

    // mem_d is the array as it stands after this edge's write; read ports sample it.
    always_comb begin
        mem_d = mem_q;
        if (wr_en && !wr_zero) mem_d[wr_addr] = wr_merged;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else begin
            mem_q <= mem_d;
        end
    end

    reg_file_sb #(
        .ADDR_W (ADDR_W),
        .NUM_RD (NUM_RD)
    ) u_sb (
        .clk      (clk),
        .rst      (rst),
        .set      (sb_set && !sb_zero),
        .set_addr (sb_addr),
        .clr      (wr_en),
        .clr_addr (wr_addr),
        .rd_addr  (rd_addr),
        .busy_nxt (busy_nxt)
    );

    for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
        logic [ADDR_W-1:0] addr_k;
        logic              zero_k;
        logic [DATA_W-1:0] data_d;
        logic [DATA_W-1:0] data_q;
        logic              busy_d;
        logic              busy_q;

        assign addr_k = rd_addr[k*ADDR_W +: ADDR_W];
        assign zero_k = zero_hit(ADDR_W_MAX'(addr_k), ZERO_EN);

        always_comb begin
            data_d = data_q;
            busy_d = busy_q;
            if (rd_en[k]) begin
                data_d = zero_k ? '0   : mem_d[addr_k];
                busy_d = zero_k ? 1'b0 : busy_nxt[k];
            end
        end

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                data_q <= '0;
                busy_q <= 1'b0;
            end else begin
                data_q <= data_d;
                busy_q <= busy_d;
            end
        end

        assign rd_data[k*DATA_W +: DATA_W] = data_q;
        assign rd_busy[k]                  = busy_q;
    end

endmodule
